// File: rtl/delay_tap_calibrator.sv
// rtl/delay_tap_calibrator.sv - sweeps a muxed delay line for the first high tap and locks to it
// Optional DDCB_SYNC_EN: two-flop sample synchronizer (single input flop when undefined).
module delay_tap_calibrator #(
  parameter  int INPUTS  = 4,
  parameter  int SAMPLES = 16,
  parameter  int SETTLE  = 4,
  localparam int SW      = $clog2(INPUTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sample_in,
  output logic [SW-1:0] select,
  output logic          busy,
  output logic          done,
  output logic          locked,
  output logic          err,
  output logic [SW-1:0] lock_tap
);

  localparam int OW   = $clog2(SAMPLES + 1);
  localparam int MAXC = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
  localparam int CW   = $clog2(MAXC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t        state_q;
  logic [SW-1:0] select_q;
  logic [SW-1:0] lock_tap_q;
  logic          busy_q;
  logic          done_q;
  logic          locked_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic [OW-1:0] ones_q;
  logic [OW-1:0] ones_d;
  logic          samp;
  logic          tap_high;

`ifdef DDCB_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], sample_in};
  end
  assign samp = sync_q[1];
`else
  logic sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 1'b0;
    else     sync_q <= sample_in;
  end
  assign samp = sync_q;
`endif

  // Saturate so the count can never wrap even if the window were mis-sized.
  always_comb begin
    ones_d = ones_q;
    if (ones_q != OW'(SAMPLES)) ones_d = ones_q + OW'(samp);
  end

  // A tie (exactly half ones) is treated as low.
  assign tap_high = ((32'(ones_q)) << 1) > 32'(SAMPLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      select_q   <= '0;
      lock_tap_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      ones_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_LOCKED, ST_FAIL: begin
          if (start) begin
            state_q  <= ST_SETTLE;
            select_q <= '0;
            busy_q   <= 1'b1;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            ones_q   <= '0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CW'(SETTLE - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          ones_q <= ones_d;
          if (cnt_q == CW'(SAMPLES - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_EVAL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_EVAL: begin
          if (tap_high && (select_q != '0)) begin
            state_q    <= ST_LOCKED;
            lock_tap_q <= select_q;
            locked_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else if (tap_high || (select_q == SW'(INPUTS - 1))) begin
            // Edge before tap 0 or never seen: no wrap-around search.
            state_q  <= ST_FAIL;
            select_q <= '0;
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            state_q  <= ST_SETTLE;
            select_q <= select_q + 1'b1;
            ones_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign select   = select_q;
  assign lock_tap = lock_tap_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign locked   = locked_q;
  assign err      = err_q;

endmodule

// File: tb/tb_delay_tap_calibrator.sv
// tb/tb_delay_tap_calibrator.sv - directed bench for delay_tap_calibrator (INPUTS=4, SAMPLES=8, SETTLE=4)
module tb_delay_tap_calibrator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sample_in;
  logic [1:0] select;
  logic       busy, done, locked, err;
  logic [1:0] lock_tap;

  int tests = 0;
  int fails = 0;
  int cyc;
  int mode = 0;
  logic tog = 1'b0;

  delay_tap_calibrator #(.INPUTS(4), .SAMPLES(8), .SETTLE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_in(sample_in),
    .select(select), .busy(busy), .done(done), .locked(locked),
    .err(err), .lock_tap(lock_tap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  // Delay-line model: mode 0 edge at tap 2, 1 all low, 2 all high, 3 tap 1 half ones then tap 2 high.
  always_comb begin
    case (mode)
      0:       sample_in = (select >= 2'd2);
      1:       sample_in = 1'b0;
      2:       sample_in = 1'b1;
      default: sample_in = (select >= 2'd2) ? 1'b1 : ((select == 2'd1) ? tog : 1'b0);
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(inout int c, input int hold);
    while (c < 300) begin
      @(negedge clk);
      c++;
      if (c >= hold) start = 1'b0;
      if (done) break;
    end
  endtask

  // Called at a negedge; cycle 0 is the cycle in which start is first high.
  task automatic run_sweep(input int hold, output int c);
    start = 1'b1;
    c = 0;
    wait_done(c, hold);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_select", select, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_lock_tap", lock_tap, 0);
    rst = 1'b0;
    @(negedge clk);

    mode = 2;
    run_sweep(1, cyc);
    check("high_done_cycle", cyc, 14);
    check("high_err", err, 1);
    check("high_locked", locked, 0);
    check("high_lock_tap", lock_tap, 0);
    check("high_busy", busy, 0);
    check("high_select", select, 0);

    mode = 0;
    run_sweep(10, cyc);
    check("edge2_done_cycle", cyc, 40);
    check("edge2_locked", locked, 1);
    check("edge2_lock_tap", lock_tap, 2);
    check("edge2_select", select, 2);
    check("edge2_err", err, 0);
    check("edge2_busy", busy, 0);

    start = 1'b1;
    @(negedge clk);
    check("relock_locked_drop", locked, 0);
    check("relock_busy", busy, 1);
    check("relock_select", select, 0);
    check("relock_done_low", done, 0);
    cyc = 1;
    wait_done(cyc, 1);
    check("relock_done_cycle", cyc, 40);
    check("relock_lock_tap", lock_tap, 2);
    @(negedge clk);
    check("done_single_pulse", done, 0);
    check("locked_holds", locked, 1);

    mode = 1;
    run_sweep(1, cyc);
    check("low_done_cycle", cyc, 53);
    check("low_err", err, 1);
    check("low_locked", locked, 0);
    check("low_select", select, 0);

    mode = 3;
    run_sweep(1, cyc);
    check("tie_done_cycle", cyc, 40);
    check("tie_locked", locked, 1);
    check("tie_lock_tap", lock_tap, 2);

    mode = 0;
    start = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    check("mid_select_tap1", select, 1);
    check("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_select", select, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_lock_tap", lock_tap, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_sweep(1, cyc);
    check("post_rst_done_cycle", cyc, 40);
    check("post_rst_locked", locked, 1);
    check("post_rst_lock_tap", lock_tap, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/delay_tap_calibrator.md
DELAY_TAP_CALIBRATOR -- requirements
Module: delay_tap_calibrator

Interface
REQ-001 Parameter: INPUTS, default 4, number of delay taps on the muxed delay line (power of two, >=2).
REQ-002 Parameter: SAMPLES, default 16, samples taken per tap (>=2, even).
REQ-003 Parameter: SETTLE, default 4, settle cycles after each select change (>=1; >=3 when DDCB_SYNC_EN defined).
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: rst  in  1  asynchronous active-high reset.
REQ-006 Port: start  in  1  level; sampled high in IDLE/LOCKED/FAIL begins a sweep.
REQ-007 Port: sample_in  in  1  muxed delay-line output to be measured.
REQ-008 Port: select  out  $clog2(INPUTS)  tap select driven to the delay mux.
REQ-009 Port: busy  out  1  high while a sweep is in progress.
REQ-010 Port: done  out  1  single-cycle pulse when a sweep ends (lock or fail).
REQ-011 Port: locked  out  1  high after a successful sweep, until next start or reset.
REQ-012 Port: err  out  1  high after a failed sweep, until next start or reset.
REQ-013 Port: lock_tap  out  $clog2(INPUTS)  tap index found by the last successful sweep.

Function
REQ-014 States SHALL be: IDLE, SETTLE, SAMPLE, EVAL, LOCKED, FAIL.
REQ-015 On start=1 in IDLE, LOCKED or FAIL, the next cycle SHALL enter SETTLE with select=0, busy=1, locked=0, err=0, ones counter cleared.
REQ-016 SETTLE SHALL last exactly SETTLE cycles, then enter SAMPLE; no samples are counted in SETTLE.
REQ-017 SAMPLE SHALL last exactly SAMPLES cycles, adding the (synchronized) sample bit to a ones counter of width $clog2(SAMPLES+1); counter never wraps.
REQ-018 EVAL SHALL last one cycle; tap is "high" iff ones*2 > SAMPLES (exact tie = low).
REQ-019 EVAL, tap 0 high: enter FAIL (edge precedes tap range).
REQ-020 EVAL, tap k>0 high: lock_tap=k, select held at k, enter LOCKED.
REQ-021 EVAL, tap low and select<INPUTS-1: select increments by 1, counter clears, enter SETTLE.
REQ-022 EVAL, tap low and select=INPUTS-1: enter FAIL, select returns to 0 (no wrap-around search).
REQ-023 Per-tap cost SHALL be SETTLE+SAMPLES+1 cycles; done SHALL pulse in the first cycle of LOCKED/FAIL, with busy=0 and locked/err valid in that same cycle.
REQ-024 start asserted while busy=1 SHALL be ignored.
REQ-025 In LOCKED, select SHALL equal lock_tap; in IDLE and FAIL, select SHALL be 0.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, select=0, busy=0, done=0, locked=0, err=0, lock_tap=0, counters and synchronizer flops 0, including mid-sweep.
REQ-027 After rst deasserts, the first start SHALL behave per REQ-015.

Configuration
REQ-028 Macro DDCB_SYNC_EN defined: sample_in SHALL pass through a two-flop synchronizer before counting (2-cycle latency absorbed by SETTLE).
REQ-029 Macro DDCB_SYNC_EN undefined: sample_in SHALL be registered by a single flop before counting; all other timing unchanged.

Verification (INPUTS=4, SAMPLES=8, SETTLE=4, DDCB_SYNC_EN defined)
REQ-030 sample_in=0 for taps 0-1, 1 for taps 2-3, start pulse at cycle 0 -> done at cycle 40, locked=1, lock_tap=2, select=2, err=0.
REQ-031 sample_in held 0 -> done at cycle 53, err=1, locked=0, select=0.
REQ-032 sample_in held 1 -> done at cycle 14, err=1, lock_tap=0.
REQ-033 Tap 1 sees exactly 4 ones of 8, tap 2 sees 8 -> tap 1 judged low, lock_tap=2.
REQ-034 rst pulsed during SAMPLE of tap 1 -> all outputs 0 immediately; new start completes a normal sweep.
REQ-035 start re-asserted during busy -> ignored, sweep timing unchanged; start in LOCKED -> locked drops next cycle, new sweep from tap 0.
